// File: rtl/reaction_trial_sequencer.sv
// Multi-trial reaction-timer controller: random delay, LED stimulus, ms response capture, sum/average.
// Optional BEST_DISPLAY_EN: in DONE, stop toggles the display between average and best time.
module reaction_trial_sequencer #(
    parameter int NUM_TRIALS  = 4,
    parameter int MIN_DELAY_S = 2,
    parameter int TIMEOUT_MS  = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        tick_ms,
    input  logic [3:0]  rand_val,
    output logic        led,
    output logic [13:0] disp_val,
    output logic [2:0]  disp_mode,
    output logic [3:0]  trial_idx,
    output logic        done
);

    localparam int          SHIFT     = $clog2(NUM_TRIALS);
    localparam logic [13:0] TIMEOUT_V = 14'(TIMEOUT_MS);
    localparam logic [3:0]  LAST_IDX  = 4'(NUM_TRIALS - 1);
    localparam logic [3:0]  MIN_S     = 4'(MIN_DELAY_S);
    localparam logic [13:0] ERR_VAL   = 14'd9999;

    localparam logic [2:0] MODE_BLANK = 3'd0;
    localparam logic [2:0] MODE_HI    = 3'd1;
    localparam logic [2:0] MODE_NUM   = 3'd2;
    localparam logic [2:0] MODE_AVG   = 3'd3;
`ifdef BEST_DISPLAY_EN
    localparam logic [2:0] MODE_BEST  = 3'd4;
`endif
    localparam logic [2:0] MODE_ERR   = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_REACT,
        S_RECORD,
        S_GAP,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [13:0] dly_cnt_q, dly_cnt_d;
    logic [13:0] target_q, target_d;
    logic [13:0] ms_cnt_q, ms_cnt_d;
    logic [13:0] rec_q, rec_d;
    logic [13:0] sum_q, sum_d;
    logic [3:0]  trial_idx_q, trial_idx_d;
    logic        led_q, led_d;
    logic [13:0] disp_val_q, disp_val_d;
    logic [2:0]  disp_mode_q, disp_mode_d;
    logic        done_q, done_d;
    logic        clear_stats;
`ifdef BEST_DISPLAY_EN
    logic [13:0] best_q, best_d;
    logic        show_best_q, show_best_d;
`endif

    function automatic logic [13:0] delay_ms(input logic [3:0] secs);
        logic [3:0] s;
        s = (secs < MIN_S) ? MIN_S : secs;
        return 14'(s) * 14'd1000;
    endfunction

    always_comb begin
        state_d     = state_q;
        dly_cnt_d   = dly_cnt_q;
        target_d    = target_q;
        ms_cnt_d    = ms_cnt_q;
        rec_d       = rec_q;
        sum_d       = sum_q;
        trial_idx_d = trial_idx_q;
        clear_stats = 1'b0;
        led_d       = 1'b0;
        done_d      = 1'b0;
        disp_mode_d = MODE_HI;
        disp_val_d  = '0;
`ifdef BEST_DISPLAY_EN
        best_d      = best_q;
        show_best_d = show_best_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_WAIT;
                    clear_stats = 1'b1;
                end
            end
            S_WAIT: begin
                if (stop) begin
                    state_d = S_ERR;
                end else if (dly_cnt_q == target_q) begin
                    state_d  = S_REACT;
                    ms_cnt_d = '0;
                end else if (tick_ms) begin
                    dly_cnt_d = dly_cnt_q + 14'd1;
                end
            end
            S_REACT: begin
                // stop beats a coincident tick: the count shown is what gets recorded
                if (stop) begin
                    state_d = S_RECORD;
                    rec_d   = ms_cnt_q;
                end else if (ms_cnt_q == TIMEOUT_V) begin
                    state_d = S_RECORD;
                    rec_d   = TIMEOUT_V;
                end else if (tick_ms) begin
                    ms_cnt_d = ms_cnt_q + 14'd1;
                end
            end
            S_RECORD: begin
                sum_d = sum_q + rec_q;
`ifdef BEST_DISPLAY_EN
                if (rec_q < best_q) begin
                    best_d = rec_q;
                end
`endif
                if (trial_idx_q == LAST_IDX) begin
                    state_d = S_DONE;
`ifdef BEST_DISPLAY_EN
                    show_best_d = 1'b0;
`endif
                end else begin
                    state_d     = S_GAP;
                    trial_idx_d = trial_idx_q + 4'd1;
                end
            end
            S_GAP: begin
                if (start) begin
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d     = S_WAIT;
                    clear_stats = 1'b1;
                end
`ifdef BEST_DISPLAY_EN
                else if (stop) begin
                    show_best_d = ~show_best_q;
                end
`endif
            end
            S_ERR: begin
                if (start) begin
                    state_d     = S_IDLE;
                    clear_stats = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (clear_stats) begin
            sum_d       = '0;
            trial_idx_d = '0;
`ifdef BEST_DISPLAY_EN
            best_d      = TIMEOUT_V;
`endif
        end

        // rand_val is captured only on the edge that enters WAIT
        if (state_d == S_WAIT && state_q != S_WAIT) begin
            target_d  = delay_ms(rand_val);
            dly_cnt_d = '0;
        end

        case (state_d)
            S_IDLE: disp_mode_d = MODE_HI;
            S_WAIT: disp_mode_d = MODE_BLANK;
            S_REACT: begin
                led_d       = 1'b1;
                disp_mode_d = MODE_NUM;
                disp_val_d  = ms_cnt_d;
            end
            S_RECORD, S_GAP: begin
                disp_mode_d = MODE_NUM;
                disp_val_d  = rec_d;
            end
            S_DONE: begin
                done_d      = 1'b1;
                disp_mode_d = MODE_AVG;
                disp_val_d  = sum_d >> SHIFT;
`ifdef BEST_DISPLAY_EN
                if (show_best_d) begin
                    disp_mode_d = MODE_BEST;
                    disp_val_d  = best_d;
                end
`endif
            end
            S_ERR: begin
                disp_mode_d = MODE_ERR;
                disp_val_d  = ERR_VAL;
            end
            default: disp_mode_d = MODE_HI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            dly_cnt_q   <= '0;
            target_q    <= '0;
            ms_cnt_q    <= '0;
            rec_q       <= '0;
            sum_q       <= '0;
            trial_idx_q <= '0;
            led_q       <= 1'b0;
            disp_val_q  <= '0;
            disp_mode_q <= MODE_HI;
            done_q      <= 1'b0;
`ifdef BEST_DISPLAY_EN
            best_q      <= TIMEOUT_V;
            show_best_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            dly_cnt_q   <= dly_cnt_d;
            target_q    <= target_d;
            ms_cnt_q    <= ms_cnt_d;
            rec_q       <= rec_d;
            sum_q       <= sum_d;
            trial_idx_q <= trial_idx_d;
            led_q       <= led_d;
            disp_val_q  <= disp_val_d;
            disp_mode_q <= disp_mode_d;
            done_q      <= done_d;
`ifdef BEST_DISPLAY_EN
            best_q      <= best_d;
            show_best_q <= show_best_d;
`endif
        end
    end

    assign led       = led_q;
    assign disp_val  = disp_val_q;
    assign disp_mode = disp_mode_q;
    assign trial_idx = trial_idx_q;
    assign done      = done_q;

endmodule
